// File: rtl/ethernet_support_pkg.sv
// Shared types and constants for the Ethernet/IPv4 support blocks.
// Holds the TX arbiter state/source encodings and the default packet size limit.
package ethernet_support_pkg;

  localparam int IPV4_MAX_PKT_BYTES = 1500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_FLUSH,
    ST_GAP
  } tx_arb_state_t;

  typedef enum logic {
    SRC_UDP,
    SRC_ICMP
  } tx_src_t;

endpackage

// File: rtl/ipv4_pkt_tx_arbiter.sv
// Packet-granular round-robin merge of the UDP and ICMP TX FIFOs onto one IPv4 byte stream.
// Byte path is a combinational mux from the granted source; oversize packets are cut and flushed.
module ipv4_pkt_tx_arbiter
  import ethernet_support_pkg::*;
#(
  parameter int MAX_PKT_BYTES = IPV4_MAX_PKT_BYTES,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        i_txmac_clk,
  input  logic        i_txmac_arst,
  input  logic        i_udp_pkt_byte_rdy,
  input  logic [7:0]  i_udp_pkt_byte,
  input  logic        i_udp_pkt_byte_vld,
  input  logic        i_udp_pkt_last_byte,
  output logic        o_udp_pkt_byte_rd,
  input  logic        i_icmp_pkt_byte_rdy,
  input  logic [7:0]  i_icmp_pkt_byte,
  input  logic        i_icmp_pkt_byte_vld,
  input  logic        i_icmp_pkt_last_byte,
  output logic        o_icmp_pkt_byte_rd,
  output logic [7:0]  o_ipv4_pkt_byte,
  output logic        o_ipv4_pkt_byte_vld,
  output logic        o_ipv4_pkt_last_byte,
  input  logic        i_ipv4_pkt_byte_rd,
  output logic        o_pkt_truncated,
  output logic [15:0] o_udp_pkt_cnt,
  output logic [15:0] o_icmp_pkt_cnt
);

  localparam int BW = $clog2(MAX_PKT_BYTES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] TRUNC_AT = BW'(MAX_PKT_BYTES - 1);
  localparam logic [GW-1:0] GAP_END  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // With no gap configured the end of a packet returns straight to arbitration.
  localparam tx_arb_state_t POST_PKT = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  tx_arb_state_t state;
  tx_src_t       grant;
  tx_src_t       last_served;
  logic [BW-1:0] byte_cnt;
  logic [GW-1:0] gap_cnt;

  logic       src_vld;
  logic       src_last;
  logic [7:0] src_byte;
  logic       xfer;
  logic       flush;
  logic       at_limit;
  logic       consume;
  logic       src_pop;

  always_comb begin
    src_vld  = (grant == SRC_UDP) ? i_udp_pkt_byte_vld  : i_icmp_pkt_byte_vld;
    src_last = (grant == SRC_UDP) ? i_udp_pkt_last_byte : i_icmp_pkt_last_byte;
    src_byte = (grant == SRC_UDP) ? i_udp_pkt_byte      : i_icmp_pkt_byte;
    xfer     = (state == ST_XFER);
    flush    = (state == ST_FLUSH);
    at_limit = (byte_cnt == TRUNC_AT);
    consume  = xfer & src_vld & i_ipv4_pkt_byte_rd;
    src_pop  = consume | (flush & src_vld);
  end

  assign o_udp_pkt_byte_rd    = src_pop & (grant == SRC_UDP);
  assign o_icmp_pkt_byte_rd   = src_pop & (grant == SRC_ICMP);
  assign o_ipv4_pkt_byte_vld  = xfer & src_vld;
  assign o_ipv4_pkt_byte      = o_ipv4_pkt_byte_vld ? src_byte : 8'd0;
  assign o_ipv4_pkt_last_byte = o_ipv4_pkt_byte_vld & (src_last | at_limit);

  always_ff @(posedge i_txmac_clk or posedge i_txmac_arst) begin
    if (i_txmac_arst) begin
      state           <= ST_IDLE;
      grant           <= SRC_UDP;
      last_served     <= SRC_ICMP;
      byte_cnt        <= '0;
      gap_cnt         <= '0;
      o_pkt_truncated <= 1'b0;
      o_udp_pkt_cnt   <= 16'd0;
      o_icmp_pkt_cnt  <= 16'd0;
    end else begin
      o_pkt_truncated <= 1'b0;
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          // UDP wins when alone or when ICMP was served last.
          if (i_udp_pkt_byte_rdy && (!i_icmp_pkt_byte_rdy || last_served == SRC_ICMP)) begin
            grant <= SRC_UDP;
            state <= ST_XFER;
          end else if (i_icmp_pkt_byte_rdy) begin
            grant <= SRC_ICMP;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (consume) begin
            if (src_last || at_limit) begin
              if (grant == SRC_UDP) o_udp_pkt_cnt  <= o_udp_pkt_cnt + 16'd1;
              else                  o_icmp_pkt_cnt <= o_icmp_pkt_cnt + 16'd1;
              last_served <= grant;
              byte_cnt    <= '0;
              gap_cnt     <= '0;
              if (src_last) begin
                state <= POST_PKT;
              end else begin
                o_pkt_truncated <= 1'b1;
                state           <= ST_FLUSH;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (src_vld && src_last) begin
            gap_cnt <= '0;
            state   <= POST_PKT;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_END) state <= ST_IDLE;
          else                    gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_pkt_tx_arbiter.sv
// Scoreboard bench for ipv4_pkt_tx_arbiter: modelled packet FIFOs feed directed packets,
// a negedge monitor pops expected bytes and checks order, last flags, gaps and rd legality.
module tb_ipv4_pkt_tx_arbiter;

  localparam int MAXB = 1500;
  localparam int GAP  = 4;

  logic        clk;
  logic        rst;
  logic        udp_rdy, udp_vld, udp_last, udp_rd;
  logic [7:0]  udp_byte;
  logic        icmp_rdy, icmp_vld, icmp_last, icmp_rd;
  logic [7:0]  icmp_byte;
  logic [7:0]  out_byte;
  logic        out_vld, out_last, tx_rd, trunc;
  logic [15:0] udp_cnt, icmp_cnt;

  ipv4_pkt_tx_arbiter #(.MAX_PKT_BYTES(MAXB), .GAP_CYCLES(GAP)) dut (
    .i_txmac_clk         (clk),
    .i_txmac_arst        (rst),
    .i_udp_pkt_byte_rdy  (udp_rdy),
    .i_udp_pkt_byte      (udp_byte),
    .i_udp_pkt_byte_vld  (udp_vld),
    .i_udp_pkt_last_byte (udp_last),
    .o_udp_pkt_byte_rd   (udp_rd),
    .i_icmp_pkt_byte_rdy (icmp_rdy),
    .i_icmp_pkt_byte     (icmp_byte),
    .i_icmp_pkt_byte_vld (icmp_vld),
    .i_icmp_pkt_last_byte(icmp_last),
    .o_icmp_pkt_byte_rd  (icmp_rd),
    .o_ipv4_pkt_byte     (out_byte),
    .o_ipv4_pkt_byte_vld (out_vld),
    .o_ipv4_pkt_last_byte(out_last),
    .i_ipv4_pkt_byte_rd  (tx_rd),
    .o_pkt_truncated     (trunc),
    .o_udp_pkt_cnt       (udp_cnt),
    .o_icmp_pkt_cnt      (icmp_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] b;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ub[$];
  logic [7:0] ib[$];
  logic       ul[$];
  logic       il[$];
  int  unp, inp;
  bit  u_stall, i_stall, stall_en, throttle_en;
  int  n_cmp, n_bad, cyc, out_cnt, trunc_cnt, last_cyc;
  bit  have_last, in_pkt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_src();
    udp_rdy   = (unp > 0);
    udp_vld   = (ub.size() > 0) && !u_stall;
    udp_byte  = (ub.size() > 0) ? ub[0] : 8'd0;
    udp_last  = (ub.size() > 0) ? ul[0] : 1'b0;
    icmp_rdy  = (inp > 0);
    icmp_vld  = (ib.size() > 0) && !i_stall;
    icmp_byte = (ib.size() > 0) ? ib[0] : 8'd0;
    icmp_last = (ib.size() > 0) ? il[0] : 1'b0;
  endtask

  // Source packet into a modelled FIFO; src 0 = UDP, 1 = ICMP.
  task automatic add_pkt(input int src, input int len, input logic [7:0] seed);
    for (int i = 0; i < len; i++) begin
      if (src == 0) begin ub.push_back(seed + 8'(i)); ul.push_back(i == len - 1); end
      else          begin ib.push_back(seed + 8'(i)); il.push_back(i == len - 1); end
    end
    if (src == 0) unp++; else inp++;
    drive_src();
  endtask

  // Expected output: first fwd bytes of the packet, last flag on byte fwd.
  task automatic exp_pkt(input int fwd, input logic [7:0] seed);
    exp_t e;
    for (int i = 0; i < fwd; i++) begin
      e.b = seed + 8'(i);
      e.l = (i == fwd - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || ub.size() != 0 || ib.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size() + ub.size() + ib.size()), 32'd0);
    repeat (GAP + 4) tick();
  endtask

  // FIFO model: pops decided from rd sampled at negedge, applied just after the edge.
  initial begin
    bit pu, pi;
    forever begin
      @(negedge clk);
      pu = udp_rd;
      pi = icmp_rd;
      @(posedge clk);
      #1;
      if (!rst) begin
        if (pu && ub.size() > 0) begin
          if (ul[0]) unp--;
          void'(ub.pop_front());
          void'(ul.pop_front());
        end
        if (pi && ib.size() > 0) begin
          if (il[0]) inp--;
          void'(ib.pop_front());
          void'(il.pop_front());
        end
      end
      u_stall = stall_en && ($urandom % 3 == 0);
      i_stall = stall_en && ($urandom % 3 == 0);
      tx_rd   = throttle_en ? 1'($urandom % 2) : 1'b1;
      drive_src();
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (trunc) trunc_cnt++;
      if (udp_rd)  check("udp_rd_needs_vld", 32'(udp_vld), 32'd1);
      if (icmp_rd) check("icmp_rd_needs_vld", 32'(icmp_vld), 32'd1);
      if (udp_rd && icmp_rd) check("both_rd", 32'(icmp_rd), 32'd0);
      if (out_vld && !in_pkt) begin
        in_pkt = 1'b1;
        if (have_last) begin
          n_cmp++;
          if (cyc - last_cyc < GAP + 2) begin
            n_bad++;
            $display("FAIL pkt_gap: got %0d cycles, required >= %0d", cyc - last_cyc, GAP + 2);
          end
        end
      end
      if (out_vld && tx_rd) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got 0x%02h, expected no byte", out_byte);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(out_byte), 32'(e.b));
          check("last", 32'(out_last), 32'(e.l));
        end
        if (out_last) begin
          in_pkt    = 1'b0;
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
    end
  end

  initial begin
    int base, k;
    n_cmp = 0; n_bad = 0; cyc = 0; out_cnt = 0; trunc_cnt = 0;
    unp = 0; inp = 0; u_stall = 0; i_stall = 0; stall_en = 0; throttle_en = 0;
    have_last = 0; in_pkt = 0; last_cyc = 0;
    tx_rd = 1'b1;
    rst = 1'b1;
    drive_src();
    repeat (3) tick();
    check("rst_vld", 32'(out_vld), 32'd0);
    check("rst_byte", 32'(out_byte), 32'd0);
    check("rst_udp_cnt", 32'(udp_cnt), 32'd0);
    check("rst_icmp_cnt", 32'(icmp_cnt), 32'd0);
    check("rst_trunc", 32'(trunc), 32'd0);
    rst = 1'b0;
    tick();

    // Tie on every arbitration: UDP first after reset, then alternate.
    add_pkt(0, 5, 8'h10); add_pkt(0, 6, 8'h20); add_pkt(0, 7, 8'h30);
    add_pkt(1, 4, 8'h40); add_pkt(1, 8, 8'h50); add_pkt(1, 3, 8'h60);
    exp_pkt(5, 8'h10); exp_pkt(4, 8'h40); exp_pkt(6, 8'h20);
    exp_pkt(8, 8'h50); exp_pkt(7, 8'h30); exp_pkt(3, 8'h60);
    wait_done("rr_drain", 500);
    check("rr_udp_cnt", 32'(udp_cnt), 32'd3);
    check("rr_icmp_cnt", 32'(icmp_cnt), 32'd3);

    add_pkt(0, 20, 8'h01);
    exp_pkt(20, 8'h01);
    wait_done("udp20_drain", 200);
    check("udp20_cnt", 32'(udp_cnt), 32'd4);

    // Oversize UDP: cut at MAXB, remainder flushed, then an intact ICMP packet.
    base = out_cnt;
    add_pkt(0, 1600, 8'h80);
    exp_pkt(MAXB, 8'h80);
    k = 0;
    while (out_cnt == base && k < 50) begin tick(); k++; end
    add_pkt(1, 10, 8'hC0);
    exp_pkt(10, 8'hC0);
    wait_done("trunc_drain", 4000);
    check("trunc_pulses", 32'(trunc_cnt), 32'd1);
    check("trunc_udp_cnt", 32'(udp_cnt), 32'd5);
    check("trunc_icmp_cnt", 32'(icmp_cnt), 32'd4);

    add_pkt(0, MAXB, 8'h33);
    exp_pkt(MAXB, 8'h33);
    wait_done("exact_drain", 4000);
    check("exact_no_trunc", 32'(trunc_cnt), 32'd1);
    check("exact_udp_cnt", 32'(udp_cnt), 32'd6);

    throttle_en = 1; stall_en = 1;
    add_pkt(1, 64, 8'h5A);
    exp_pkt(64, 8'h5A);
    wait_done("throttle_drain", 2000);
    throttle_en = 0; stall_en = 0;
    check("throttle_icmp_cnt", 32'(icmp_cnt), 32'd5);

    // Reset after the tenth byte of a 40-byte packet.
    base = out_cnt;
    add_pkt(0, 40, 8'h70);
    exp_pkt(40, 8'h70);
    k = 0;
    while (out_cnt < base + 10 && k < 200) begin tick(); k++; end
    check("pre_rst_bytes", 32'(out_cnt - base), 32'd10);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(out_vld), 32'd0);
    check("mid_rst_last", 32'(out_last), 32'd0);
    check("mid_rst_byte", 32'(out_byte), 32'd0);
    check("mid_rst_udp_rd", 32'(udp_rd), 32'd0);
    check("mid_rst_udp_cnt", 32'(udp_cnt), 32'd0);
    check("mid_rst_icmp_cnt", 32'(icmp_cnt), 32'd0);
    ub.delete(); ul.delete(); ib.delete(); il.delete(); exp_q.delete();
    unp = 0; inp = 0; in_pkt = 0; have_last = 0;
    drive_src();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    add_pkt(0, 8, 8'h11);
    add_pkt(1, 6, 8'h22);
    exp_pkt(8, 8'h11);
    exp_pkt(6, 8'h22);
    wait_done("post_rst_drain", 300);
    check("post_rst_udp_cnt", 32'(udp_cnt), 32'd1);
    check("post_rst_icmp_cnt", 32'(icmp_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
